lcd_lap_history: RTL and testbench

Parametrised HD44780-class character-LCD driver for the stopwatch subsystem. It keeps a circular history of captured lap times and refreshes a 2x16 display continuously after power-on initialisation. Line 1 shows the viewed lap's position in the history; line 2 shows that lap's time. It sits between the stopwatch counter, which supplies BCD lap strobes, and the LCD pins.

---
 rtl/lcd_pkg.sv | 53 +++++
 rtl/lap_history_buf.sv | 66 ++++++
 rtl/lcd_lap_history.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_lcd_lap_history.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the lap-history LCD driver: interface FSM
// states, HD44780 command bytes, ASCII glyphs and BCD digit conversion.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_FUNC_SET,
        ST_DISP_ON,
        ST_ENTRY,
        ST_L1_SET,
        ST_L1_DATA,
        ST_L2_SET,
        ST_L2_DATA
    } lcd_state_e;

    // Packed BCD lap time as delivered by the stopwatch counter.
    typedef struct packed {
        logic [3:0] m_ten;
        logic [3:0] m_one;
        logic [3:0] s_ten;
        logic [3:0] s_one;
        logic [3:0] c_ten;
        logic [3:0] c_one;
    } lap_time_t;

    localparam int LINE_LEN = 16;

    localparam logic [7:0] CMD_IDLE     = 8'h00;
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_L1_SET   = 8'h80;
    localparam logic [7:0] CMD_L2_SET   = 8'hC0;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_L     = 8'h4C;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_T     = 8'h54;
    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_M     = 8'h4D;
    localparam logic [7:0] ASC_E     = 8'h45;

    function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
        return ASC_ZERO + {4'h0, nib};
    endfunction

endpackage

// File: rtl/lap_history_buf.sv
// Circular lap-time history. Pushes overwrite the oldest entry once full;
// reads are combinational and addressed relative to the newest entry.
module lap_history_buf
    import lcd_pkg::*;
#(
    parameter int LAP_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         clear_i,
    input  lap_time_t                    data_i,
    input  logic [$clog2(LAP_DEPTH)-1:0] rd_ofs_i,
    output logic [$clog2(LAP_DEPTH):0]   count_o,
    output lap_time_t                    rd_data_o
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;

    lap_time_t         mem_q [LAP_DEPTH];
    logic [AW-1:0]     wp_q, wp_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     rd_addr;

    // Next write pointer and occupancy; clear wins over a simultaneous push.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        if (clear_i) begin
            wp_d    = '0;
            count_d = '0;
        end else if (push_i) begin
            wp_d = wp_q + 1'b1;
            if (count_q != CW'(LAP_DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, so process order cannot matter.
        if (rst) begin
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Entry storage written at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; lap_count gates every read, so stale contents are never shown and the array maps to plain RAM.
        if (push_i && !clear_i) begin
            mem_q[wp_q] <= data_i;
        end
    end

    // Offset 0 is the entry written most recently (one behind wp).
    assign rd_addr   = wp_q - AW'(1) - rd_ofs_i;
    assign rd_data_o = mem_q[rd_addr];
    assign count_o   = count_q;

endmodule

// File: rtl/lcd_lap_history.sv
// HD44780 2x16 driver showing a scrollable lap history.
// Line 1: "LAP ii/nn", line 2: "TIME:mm:ss.cc" of the viewed lap.
// Optional macro LCD_LAP_SCROLL_EN enables scroll_up/scroll_dn; without it
// the newest lap is always shown.
module lcd_lap_history
    import lcd_pkg::*;
#(
    parameter int DIV       = 10,
    parameter int PWR_DELAY = 20,
    parameter int LAP_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_mode,
    input  logic                       lap_valid,
    input  logic [23:0]                lap_time,
    input  logic                       lap_clear,
    input  logic                       scroll_up,
    input  logic                       scroll_dn,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       LCD_E,
    output logic                       LCD_RS,
    output logic                       LCD_RW,
    output logic [7:0]                 LCD_DATA
);

    localparam int SW  = $clog2(LAP_DEPTH);
    localparam int CW  = SW + 1;
    localparam int DCW = $clog2(DIV);
    localparam int PCW = $clog2(PWR_DELAY + 1);

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic           tick_q;

    assign div_cnt_d = (div_cnt_q == DCW'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;

    // Free-running divider; tick is registered so LCD_E is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= (div_cnt_q == DCW'(DIV - 1));
        end
    end

    // ------------------------------------------------------------------
    // History buffer and view offset
    // ------------------------------------------------------------------
    logic [SW-1:0] sel_q;
    lap_time_t     rd_data;

    lap_history_buf #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push_i    (lap_valid),
        .clear_i   (lap_clear),
        .data_i    (lap_time),
        .rd_ofs_i  (sel_q),
        .count_o   (lap_count),
        .rd_data_o (rd_data)
    );

`ifdef LCD_LAP_SCROLL_EN
    logic [SW-1:0] sel_d;

    // View offset: clear/push snap to newest; opposing scrolls cancel.
    always_comb begin
        // NOTE: assigning every always_comb output first guarantees no path leaves it unassigned, so no latch is inferred.
        sel_d = sel_q;
        if (lap_clear || lap_valid) begin
            sel_d = '0;
        end else if (scroll_up && !scroll_dn) begin
            if (({1'b0, sel_q} + CW'(1)) < lap_count) begin
                sel_d = sel_q + 1'b1;
            end
        end else if (scroll_dn && !scroll_up) begin
            if (sel_q != '0) begin
                sel_d = sel_q - 1'b1;
            end
        end
    end

    // View offset register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end
`else
    logic unused_scroll;

    assign sel_q         = '0;
    assign unused_scroll = scroll_up | scroll_dn;
`endif

    // ------------------------------------------------------------------
    // Frame snapshot and text formatting
    // ------------------------------------------------------------------
    lap_time_t      snap_time_q, snap_time_d;
    logic [CW-1:0]  snap_idx_q, snap_idx_d;
    logic [CW-1:0]  snap_cnt_q, snap_cnt_d;
    logic [7:0]     line1_c [LINE_LEN];
    logic [7:0]     line2_c [LINE_LEN];
    logic [15:0]    idx_asc, cnt_asc;

    function automatic logic [15:0] dec2_ascii(input logic [6:0] v);
        return {digit_ascii(4'(v / 7'd10)), digit_ascii(4'(v % 7'd10))};
    endfunction

    assign idx_asc = dec2_ascii(7'(snap_idx_q));
    assign cnt_asc = dec2_ascii(7'(snap_cnt_q));

    // Build both 16-byte lines from the snapshot; blanks when sw_mode is 0.
    always_comb begin
        for (int i = 0; i < LINE_LEN; i++) begin
            line1_c[i] = ASC_SPACE;
            line2_c[i] = ASC_SPACE;
        end
        if (sw_mode) begin
            line1_c[0]  = ASC_L;
            line1_c[1]  = ASC_A;
            line1_c[2]  = ASC_P;
            line1_c[6]  = ASC_SLASH;
            line1_c[7]  = cnt_asc[15:8];
            line1_c[8]  = cnt_asc[7:0];
            line2_c[0]  = ASC_T;
            line2_c[1]  = ASC_I;
            line2_c[2]  = ASC_M;
            line2_c[3]  = ASC_E;
            line2_c[4]  = ASC_COLON;
            line2_c[7]  = ASC_COLON;
            line2_c[10] = ASC_DOT;
            if (snap_cnt_q == '0) begin
                line1_c[4]  = ASC_DASH;
                line1_c[5]  = ASC_DASH;
                line2_c[5]  = ASC_DASH;
                line2_c[6]  = ASC_DASH;
                line2_c[8]  = ASC_DASH;
                line2_c[9]  = ASC_DASH;
                line2_c[11] = ASC_DASH;
                line2_c[12] = ASC_DASH;
            end else begin
                line1_c[4]  = idx_asc[15:8];
                line1_c[5]  = idx_asc[7:0];
                line2_c[5]  = digit_ascii(snap_time_q.m_ten);
                line2_c[6]  = digit_ascii(snap_time_q.m_one);
                line2_c[8]  = digit_ascii(snap_time_q.s_ten);
                line2_c[9]  = digit_ascii(snap_time_q.s_one);
                line2_c[11] = digit_ascii(snap_time_q.c_ten);
                line2_c[12] = digit_ascii(snap_time_q.c_one);
            end
        end
    end

    // ------------------------------------------------------------------
    // LCD interface FSM: state_q names the byte currently on the pins
    // ------------------------------------------------------------------
    lcd_state_e     state_q, state_d;
    logic [PCW-1:0] dly_q, dly_d;
    logic [3:0]     chr_q, chr_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;
    logic           enter_l1;

    // Next byte and state, evaluated only on tick cycles.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        chr_d       = chr_q;
        rs_d        = rs_q;
        data_d      = data_q;
        snap_time_d = snap_time_q;
        snap_idx_d  = snap_idx_q;
        snap_cnt_d  = snap_cnt_q;
        enter_l1    = 1'b0;
        if (tick_q) begin
            unique case (state_q)
                ST_DELAY: begin
                    rs_d = 1'b0;
                    if (dly_q == PCW'(PWR_DELAY - 1)) begin
                        state_d = ST_FUNC_SET;
                        data_d  = CMD_FUNC_SET;
                    end else begin
                        dly_d  = dly_q + 1'b1;
                        data_d = CMD_IDLE;
                    end
                end
                ST_FUNC_SET: begin
                    state_d = ST_DISP_ON;
                    rs_d    = 1'b0;
                    data_d  = CMD_DISP_ON;
                end
                ST_DISP_ON: begin
                    state_d = ST_ENTRY;
                    rs_d    = 1'b0;
                    data_d  = CMD_ENTRY;
                end
                ST_ENTRY: begin
                    enter_l1 = 1'b1;
                end
                ST_L1_SET: begin
                    state_d = ST_L1_DATA;
                    chr_d   = '0;
                    rs_d    = 1'b1;
                    data_d  = line1_c[0];
                end
                ST_L1_DATA: begin
                    if (chr_q == 4'(LINE_LEN - 1)) begin
                        state_d = ST_L2_SET;
                        rs_d    = 1'b0;
                        data_d  = CMD_L2_SET;
                    end else begin
                        chr_d  = chr_q + 4'd1;
                        rs_d   = 1'b1;
                        data_d = line1_c[chr_q + 4'd1];
                    end
                end
                ST_L2_SET: begin
                    state_d = ST_L2_DATA;
                    chr_d   = '0;
                    rs_d    = 1'b1;
                    data_d  = line2_c[0];
                end
                ST_L2_DATA: begin
                    if (chr_q == 4'(LINE_LEN - 1)) begin
                        enter_l1 = 1'b1;
                    end else begin
                        chr_d  = chr_q + 4'd1;
                        rs_d   = 1'b1;
                        data_d = line2_c[chr_q + 4'd1];
                    end
                end
                default: begin
                    state_d = ST_DELAY;
                end
            endcase
            // Issuing the line-1 address latches the frame's snapshot.
            if (enter_l1) begin
                state_d     = ST_L1_SET;
                rs_d        = 1'b0;
                data_d      = CMD_L1_SET;
                snap_time_d = rd_data;
                snap_idx_d  = lap_count - {1'b0, sel_q};
                snap_cnt_d  = lap_count;
            end
        end
    end

    // FSM, pin and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_DELAY;
            dly_q       <= '0;
            chr_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= CMD_IDLE;
            snap_time_q <= '0;
            snap_idx_q  <= '0;
            snap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            chr_q       <= chr_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            snap_time_q <= snap_time_d;
            snap_idx_q  <= snap_idx_d;
            snap_cnt_q  <= snap_cnt_d;
        end
    end

    assign LCD_E    = tick_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_lap_history.sv
// Directed bench for lcd_lap_history (DIV=10, PWR_DELAY=20, LAP_DEPTH=4).
// Expected scroll results depend on whether LCD_LAP_SCROLL_EN is defined.
module tb_lcd_lap_history;

    localparam int DIV       = 10;
    localparam int PWR_DELAY = 20;
    localparam int LAP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_mode;
    logic        lap_valid;
    logic [23:0] lap_time;
    logic        lap_clear;
    logic        scroll_up;
    logic        scroll_dn;
    logic [2:0]  lap_count;
    logic        LCD_E;
    logic        LCD_RS;
    logic        LCD_RW;
    logic [7:0]  LCD_DATA;

    int checks = 0;
    int errors = 0;

    lcd_lap_history #(
        .DIV       (DIV),
        .PWR_DELAY (PWR_DELAY),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_mode   (sw_mode),
        .lap_valid (lap_valid),
        .lap_time  (lap_time),
        .lap_clear (lap_clear),
        .scroll_up (scroll_up),
        .scroll_dn (scroll_dn),
        .lap_count (lap_count),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next LCD_E pulse (sampled on the falling edge).
    task automatic wait_tick(output logic rs, output logic [7:0] d, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!LCD_E && gap < 4 * DIV);
        if (!LCD_E) check("tick_timeout", {127'b0, LCD_E}, 128'd1);
        rs = LCD_RS;
        d  = LCD_DATA;
    endtask

    // Power-on sequence: PWR_DELAY idle bytes then the four init commands.
    task automatic check_init(input string tag);
        logic        rs;
        logic [7:0]  d;
        int          gap;
        int          zeros;
        int          badgap;
        logic [31:0] cmds;
        logic [3:0]  rss;
        zeros  = 0;
        badgap = 0;
        cmds   = '0;
        rss    = '1;
        for (int i = 0; i < PWR_DELAY + 4; i++) begin
            wait_tick(rs, d, gap);
            if (i > 0 && gap != DIV) badgap++;
            if (i < PWR_DELAY) begin
                if (!rs && d == 8'h00) zeros++;
            end else begin
                cmds = {cmds[23:0], d};
                rss  = {rss[2:0], rs};
            end
        end
        check({tag, "_delay_bytes"}, zeros, PWR_DELAY);
        check({tag, "_init_cmds"}, cmds, 32'h380C_0680);
        check({tag, "_init_rs"}, rss, 4'b0000);
        check({tag, "_e_period"}, badgap, 0);
    endtask

    // Sync to a frame start and capture both lines with their RS bits.
    task automatic capture_frame(output logic [127:0] l1, output logic [127:0] l2,
                                 output logic [31:0] rs_all);
        logic       rs;
        logic [7:0] d;
        int         gap;
        int         n;
        n = 0;
        do begin
            wait_tick(rs, d, gap);
            n++;
        end while (!(rs == 1'b0 && d == 8'hC0) && n < 80);
        if (!(rs == 1'b0 && d == 8'hC0)) check("sync_l2_set", {rs, d}, 9'h0C0);
        for (int i = 0; i < 17; i++) wait_tick(rs, d, gap);
        check("l1_set_cmd", {rs, d}, 9'h080);
        l1 = '0;
        l2 = '0;
        rs_all = '0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(rs, d, gap);
            l1 = {l1[119:0], d};
            rs_all = {rs_all[30:0], rs};
        end
        wait_tick(rs, d, gap);
        check("l2_set_cmd", {rs, d}, 9'h0C0);
        for (int i = 0; i < 16; i++) begin
            wait_tick(rs, d, gap);
            l2 = {l2[119:0], d};
            rs_all = {rs_all[30:0], rs};
        end
    endtask

    task automatic push(input logic [23:0] t, input logic clr);
        @(negedge clk);
        lap_time  = t;
        lap_valid = 1'b1;
        lap_clear = clr;
        @(negedge clk);
        lap_valid = 1'b0;
        lap_clear = 1'b0;
    endtask

    task automatic scroll(input logic up, input logic dn);
        @(negedge clk);
        scroll_up = up;
        scroll_dn = dn;
        @(negedge clk);
        scroll_up = 1'b0;
        scroll_dn = 1'b0;
        @(negedge clk);
    endtask

    logic [127:0] l1, l2;
    logic [31:0]  rs_all;
    logic [127:0] exp_a1, exp_a2, exp_b1, exp_b2;
    logic         rs_s;
    logic [7:0]   d_s;
    int           gap_s;
    int           n_s;

    initial begin
`ifdef LCD_LAP_SCROLL_EN
        exp_a1 = "LAP 01/04       ";
        exp_a2 = "TIME:02:04.06   ";
        exp_b1 = "LAP 02/04       ";
        exp_b2 = "TIME:03:11.22   ";
`else
        exp_a1 = "LAP 04/04       ";
        exp_a2 = "TIME:10:59.59   ";
        exp_b1 = "LAP 04/04       ";
        exp_b2 = "TIME:10:59.59   ";
`endif
        rst       = 1'b1;
        sw_mode   = 1'b1;
        lap_valid = 1'b0;
        lap_time  = '0;
        lap_clear = 1'b0;
        scroll_up = 1'b0;
        scroll_dn = 1'b0;
        repeat (4) @(negedge clk);

        check("rst_outputs", {LCD_E, LCD_RS, LCD_RW, LCD_DATA, lap_count}, 14'h0);
        rst = 1'b0;

        check_init("pwr");

        capture_frame(l1, l2, rs_all);
        check("empty_l1", l1, "LAP --/00       ");
        check("empty_l2", l2, "TIME:--:--.--   ");
        check("empty_rs", rs_all, 32'hFFFF_FFFF);

        push(24'h012345, 1'b0);
        check("count_after_push1", lap_count, 3'd1);
        capture_frame(l1, l2, rs_all);
        check("lap1_l1", l1, "LAP 01/01       ");
        check("lap1_l2", l2, "TIME:01:23.45   ");

        push(24'h020406, 1'b0);
        push(24'h031122, 1'b0);
        push(24'h045533, 1'b0);
        check("count_after_push4", lap_count, 3'd4);
        push(24'h105959, 1'b0);
        check("count_saturates", lap_count, 3'd4);
        repeat (5) scroll(1'b1, 1'b0);
        capture_frame(l1, l2, rs_all);
        check("scroll_top_l1", l1, exp_a1);
        check("scroll_top_l2", l2, exp_a2);

        scroll(1'b0, 1'b1);
        scroll(1'b1, 1'b1);
        capture_frame(l1, l2, rs_all);
        check("scroll_dn_l1", l1, exp_b1);
        check("scroll_dn_l2", l2, exp_b2);

        push(24'h000001, 1'b0);
        capture_frame(l1, l2, rs_all);
        check("push_resets_view_l1", l1, "LAP 04/04       ");
        check("push_resets_view_l2", l2, "TIME:00:00.01   ");

        push(24'h000009, 1'b1);
        check("clear_beats_push", lap_count, 3'd0);
        capture_frame(l1, l2, rs_all);
        check("cleared_l1", l1, "LAP --/00       ");
        check("cleared_l2", l2, "TIME:--:--.--   ");

        sw_mode = 1'b0;
        push(24'h000002, 1'b0);
        check("count_blank_mode", lap_count, 3'd1);
        capture_frame(l1, l2, rs_all);
        check("blank_l1", l1, {16{8'h20}});
        check("blank_l2", l2, {16{8'h20}});
        check("blank_rs", rs_all, 32'hFFFF_FFFF);

        // Reset while line-2 data is being written.
        n_s = 0;
        do begin
            wait_tick(rs_s, d_s, gap_s);
            n_s++;
        end while (!(rs_s == 1'b0 && d_s == 8'hC0) && n_s < 80);
        repeat (3) wait_tick(rs_s, d_s, gap_s);
        check("mid_l2_data_rs", rs_s, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midframe_rst_state", {LCD_E, LCD_RS, LCD_DATA, lap_count}, 13'h0);
        rst = 1'b0;
        check_init("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
